any1_ptw: RTL and testbench

Hardware page-table walker for the ANY-1 TLB. It responds to a TLB miss by reading a two-level page table from memory over a simple request/acknowledge read port. It then writes the resulting entry into the TLB through the TLB's software write port, using random-way replacement. It sits between the TLB miss output, the memory arbiter's read channel and the TLB write port, and reports completion or a page fault to the pipeline.

---
 rtl/any1_ptw.sv | 207 ++++++++++++++++++++
 tb/tb_any1_ptw.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_ptw.sv
// -----------------------------------------------------------------------------
// any1_ptw - hardware page-table walker for the ANY-1 TLB.
//
// On a TLB miss it reads a two-level page table over a request/acknowledge
// memory read port, then writes the resulting entry into the TLB's random way.
// It reports completion or a page fault to the pipeline.
//
// Ports:
//   rst_i, clk_i       asynchronous active-high reset, clock
//   en_i               walker enable; misses are ignored while low
//   miss_i             TLB miss (level)
//   miss_adr_i         faulting virtual address
//   asid_i             current ASID
//   ptbr_i             page-table base (2 KB aligned, bits [10:0] ignored)
//   flush_i            abort the current walk
//   mem_req_o          memory read request
//   mem_adr_o          memory read address (8-byte aligned)
//   mem_ack_i          memory read data valid
//   mem_err_i          bus error, qualifies mem_ack_i
//   mem_dat_i          memory read data
//   wrtlb_o            TLB write strobe
//   tlbadr_o           TLB write address (bit 15 selects the random way)
//   tlbdat_o           TLB write data (PTE with [63:56] = ASID)
//   busy_o             walk in progress
//   done_o             one-cycle pulse: entry written
//   fault_o            one-cycle pulse: page fault, bus error or timeout
//   fault_adr_o        virtual address of the last fault
// All outputs are registered.
// -----------------------------------------------------------------------------
module any1_ptw #(
  parameter int unsigned PTE_VBIT = 55,
  parameter int unsigned TMO      = 255
) (
  input  logic        rst_i,
  input  logic        clk_i,
  input  logic        en_i,
  input  logic        miss_i,
  input  logic [31:0] miss_adr_i,
  input  logic [7:0]  asid_i,
  input  logic [31:0] ptbr_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_adr_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [63:0] mem_dat_i,
  output logic        wrtlb_o,
  output logic [15:0] tlbadr_o,
  output logic [63:0] tlbdat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] fault_adr_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1REQ, S_L2REQ, S_WRITE, S_DONE, S_FAULT, S_DRAIN
  } state_t;

  // Counter value in the last waiting cycle before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

  state_t      state, state_nxt;
  logic [31:0] va, va_nxt;
  logic [7:0]  asid, asid_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        mem_req_nxt, wrtlb_nxt, done_nxt, fault_nxt, busy_nxt;
  logic [31:0] mem_adr_nxt, fault_adr_nxt;
  logic [15:0] tlbadr_nxt;
  logic [63:0] tlbdat_nxt;
  logic [31:0] l1_adr;
  logic [63:0] pte_asid;
  logic        timeout;

  assign timeout = (cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    va_nxt        = va;
    asid_nxt      = asid;
    cnt_nxt       = cnt;
    mem_req_nxt   = 1'b0;
    mem_adr_nxt   = mem_adr_o;
    wrtlb_nxt     = 1'b0;
    tlbadr_nxt    = tlbadr_o;
    tlbdat_nxt    = tlbdat_o;
    done_nxt      = 1'b0;
    fault_nxt     = 1'b0;
    fault_adr_nxt = fault_adr_o;

    // L1 index replaces the ignored low bits of the table base.
    l1_adr        = ptbr_i;
    l1_adr[10:0]  = {miss_adr_i[31:24], 3'b000};
    // The PTE is already in TLB format; only the ASID field is substituted.
    pte_asid          = mem_dat_i;
    pte_asid[63:56]   = asid;

    unique case (state)
      S_IDLE: begin
        if (en_i && miss_i) begin
          va_nxt      = miss_adr_i;
          asid_nxt    = asid_i;
          cnt_nxt     = '0;
          mem_req_nxt = 1'b1;
          mem_adr_nxt = l1_adr;
          state_nxt   = S_L1REQ;
        end
      end
      S_L1REQ: begin
        if (mem_ack_i) begin
          // A flush coinciding with the ack has nothing left to drain.
          if (flush_i)                         state_nxt = S_IDLE;
          else if (mem_err_i || !mem_dat_i[0]) state_nxt = S_FAULT;
          else begin
            cnt_nxt     = '0;
            mem_req_nxt = 1'b1;
            mem_adr_nxt = {mem_dat_i[31:13], va[23:14], 3'b000};
            state_nxt   = S_L2REQ;
          end
        end else if (timeout) begin
          state_nxt = flush_i ? S_IDLE : S_FAULT;
        end else begin
          cnt_nxt     = cnt + 8'd1;
          mem_req_nxt = 1'b1;
          if (flush_i) state_nxt = S_DRAIN;
        end
      end
      S_L2REQ: begin
        if (mem_ack_i) begin
          if (flush_i)                                state_nxt = S_IDLE;
          else if (mem_err_i || !mem_dat_i[PTE_VBIT]) state_nxt = S_FAULT;
          else begin
            wrtlb_nxt  = 1'b1;
            tlbadr_nxt = {1'b1, 5'b00000, va[23:14]};
            tlbdat_nxt = pte_asid;
            state_nxt  = S_WRITE;
          end
        end else if (timeout) begin
          state_nxt = flush_i ? S_IDLE : S_FAULT;
        end else begin
          cnt_nxt     = cnt + 8'd1;
          mem_req_nxt = 1'b1;
          if (flush_i) state_nxt = S_DRAIN;
        end
      end
      S_WRITE: begin
        done_nxt  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DRAIN: begin
        // Keep the request up until the outstanding read completes or the
        // watchdog gives up; neither case reports anything.
        if (mem_ack_i || timeout) state_nxt = S_IDLE;
        else begin
          cnt_nxt     = cnt + 8'd1;
          mem_req_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;  // S_DONE, S_FAULT
    endcase

    // FAULT always leaves after one cycle, so reaching it here means entry.
    if (state_nxt == S_FAULT) begin
      fault_nxt     = 1'b1;
      fault_adr_nxt = va;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values settled before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      va          <= '0;
      asid        <= '0;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_adr_o   <= '0;
      wrtlb_o     <= 1'b0;
      tlbadr_o    <= '0;
      tlbdat_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
    end else begin
      state       <= state_nxt;
      va          <= va_nxt;
      asid        <= asid_nxt;
      cnt         <= cnt_nxt;
      mem_req_o   <= mem_req_nxt;
      mem_adr_o   <= mem_adr_nxt;
      wrtlb_o     <= wrtlb_nxt;
      tlbadr_o    <= tlbadr_nxt;
      tlbdat_o    <= tlbdat_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      fault_o     <= fault_nxt;
      fault_adr_o <= fault_adr_nxt;
    end
  end

endmodule

// File: tb/tb_any1_ptw.sv
// -----------------------------------------------------------------------------
// tb_any1_ptw - self-checking bench for any1_ptw.
//
// Each walk is described by a scenario (addresses, table entries, per-access
// ack latency, bus errors, optional flush cycle). A reference model derives the
// expected outcome and cycle timing from the walk rules; the bench plays the
// memory side and compares what the walker does against that model.
// -----------------------------------------------------------------------------
module tb_any1_ptw;

  localparam int TMO  = 255;
  localparam int VBIT = 55;

  logic        rst_i, clk_i, en_i, miss_i, flush_i;
  logic        mem_ack_i, mem_err_i;
  logic [31:0] miss_adr_i, ptbr_i;
  logic [7:0]  asid_i;
  logic [63:0] mem_dat_i;
  logic        mem_req_o, wrtlb_o, busy_o, done_o, fault_o;
  logic [31:0] mem_adr_o, fault_adr_o;
  logic [15:0] tlbadr_o;
  logic [63:0] tlbdat_o;

  any1_ptw #(.PTE_VBIT(VBIT), .TMO(TMO)) dut (
    .rst_i(rst_i), .clk_i(clk_i), .en_i(en_i), .miss_i(miss_i),
    .miss_adr_i(miss_adr_i), .asid_i(asid_i), .ptbr_i(ptbr_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_dat_i(mem_dat_i),
    .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .fault_adr_o(fault_adr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] va, ptbr, va2, l1;
    logic [7:0]  asid;
    logic [63:0] l2;
    logic        err1, err2, hold;
    int          w1, w2, flush_at;
  } walk_t;

  // Edge numbers count clock edges after the capture edge (edge 0); an event
  // "at edge k" is visible in the cycle following edge k.
  typedef struct {
    int          idle_edge, pulse_edge, wr_edge, req_cycles;
    logic        is_done, is_fault;
    logic [31:0] l1_adr, l2_adr;
    logic [15:0] tadr;
    logic [63:0] tdat;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_fault_va;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic walk_t mk_walk(input logic [31:0] va, input logic [7:0] asid,
                                    input logic [31:0] ptbr, input logic [31:0] l1,
                                    input logic [63:0] l2, input logic err1, input logic err2,
                                    input int w1, input int w2, input int flush_at);
    walk_t w;
    w.va = va; w.asid = asid; w.ptbr = ptbr; w.l1 = l1; w.l2 = l2;
    w.err1 = err1; w.err2 = err2; w.w1 = w1; w.w2 = w2; w.flush_at = flush_at;
    w.hold = 1'b0; w.va2 = '0;
    return w;
  endfunction

  // Reference model: outcome and timing from the walk rules.
  function automatic exp_t model(input walk_t w);
    exp_t e;
    int   t2;
    e.l1_adr     = {w.ptbr[31:11], w.va[31:24], 3'b000};
    e.l2_adr     = {w.l1[31:13], w.va[23:14], 3'b000};
    e.tadr       = {1'b1, 5'b00000, w.va[23:14]};
    e.tdat       = {w.asid, w.l2[55:0]};
    e.is_done    = 1'b0;
    e.is_fault   = 1'b0;
    e.wr_edge    = -1;
    e.pulse_edge = -1;
    t2 = w.w1 + 1;  // edge at which the L2 request starts
    if (w.w1 < TMO && w.flush_at >= 0 && w.flush_at <= w.w1) begin
      e.idle_edge = t2; e.req_cycles = t2;                        // flushed in L1
    end else if (w.w1 >= TMO) begin
      e.is_fault = 1'b1; e.pulse_edge = TMO;                      // L1 timeout
      e.idle_edge = TMO + 1; e.req_cycles = TMO;
    end else if (w.err1 || !w.l1[0]) begin
      e.is_fault = 1'b1; e.pulse_edge = t2;                       // L1 fault
      e.idle_edge = t2 + 1; e.req_cycles = t2;
    end else if (w.w2 < TMO && w.flush_at >= t2 && w.flush_at <= t2 + w.w2) begin
      e.idle_edge = t2 + w.w2 + 1; e.req_cycles = t2 + w.w2 + 1;  // flushed in L2
    end else if (w.w2 >= TMO) begin
      e.is_fault = 1'b1; e.pulse_edge = t2 + TMO;                 // L2 timeout
      e.idle_edge = t2 + TMO + 1; e.req_cycles = t2 + TMO;
    end else if (w.err2 || !w.l2[VBIT]) begin
      e.is_fault = 1'b1; e.pulse_edge = t2 + w.w2 + 1;            // L2 fault
      e.idle_edge = e.pulse_edge + 1; e.req_cycles = t2 + w.w2 + 1;
    end else begin
      e.is_done = 1'b1; e.wr_edge = t2 + w.w2 + 1;                // success
      e.pulse_edge = e.wr_edge + 1; e.idle_edge = e.pulse_edge + 1;
      e.req_cycles = t2 + w.w2 + 1;
    end
    return e;
  endfunction

  // Runs one walk from an idle walker; the bench acts as the memory.
  task automatic run_walk(input walk_t w);
    exp_t        e;
    int          wr_cnt, wr_k, done_cnt, done_k, fault_cnt, fault_k;
    int          req_cyc, first_idle, next_req_k, acc, wait_ctr, n;
    logic        req_at_fault;
    logic [15:0] wr_adr;
    logic [63:0] wr_dat;
    logic [31:0] next_req_adr;
    logic [31:0] adrs [2];
    int          lats [2];
    logic        errs [2];
    logic [63:0] dats [2];

    e = model(w);
    wr_cnt = 0; wr_k = -1; done_cnt = 0; done_k = -1; fault_cnt = 0; fault_k = -1;
    req_cyc = 0; first_idle = -1; next_req_k = -1; acc = 0; wait_ctr = 0;
    req_at_fault = 1'bx; wr_adr = '0; wr_dat = '0; next_req_adr = '0;
    adrs[0] = e.l1_adr; adrs[1] = e.l2_adr;
    lats[0] = w.w1;     lats[1] = w.w2;
    errs[0] = w.err1;   errs[1] = w.err2;
    dats[0] = {~w.l1, w.l1};
    dats[1] = w.l2;

    miss_adr_i = w.va; asid_i = w.asid; ptbr_i = w.ptbr; miss_i = 1'b1;
    @(posedge clk_i); #1;  // capture edge
    // Changing inputs mid-walk must not affect the captured values.
    asid_i = ~w.asid; ptbr_i = ~w.ptbr;
    if (w.hold) miss_adr_i = w.va2;
    else        miss_i     = 1'b0;

    n = e.idle_edge + 3;
    for (int k = 0; k <= n; k++) begin
      if (wrtlb_o) begin wr_cnt++; wr_k = k; wr_adr = tlbadr_o; wr_dat = tlbdat_o; end
      if (done_o)  begin done_cnt++; done_k = k; end
      if (fault_o) begin fault_cnt++; fault_k = k; req_at_fault = mem_req_o; end
      if (!busy_o && first_idle < 0) first_idle = k;
      if (mem_req_o && first_idle >= 0 && next_req_k < 0) begin
        next_req_k = k; next_req_adr = mem_adr_o;
      end
      flush_i   = (k == w.flush_at);
      mem_ack_i = 1'b0;
      mem_err_i = 1'b0;
      mem_dat_i = {$urandom, $urandom};
      if (mem_req_o && first_idle < 0) begin
        req_cyc++;
        if (acc < 2) begin
          check("req_adr", 64'(mem_adr_o), 64'(adrs[acc]));
          if (wait_ctr == lats[acc]) begin
            mem_ack_i = 1'b1; mem_err_i = errs[acc]; mem_dat_i = dats[acc];
            acc++; wait_ctr = 0;
          end else begin
            wait_ctr++;
          end
        end
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0; mem_ack_i = 1'b0; mem_err_i = 1'b0;
    if (!w.hold) miss_i = 1'b0;

    if (e.is_fault) last_fault_va = w.va;
    check("wr_cnt",    64'(wr_cnt),    64'(e.is_done ? 1 : 0));
    check("done_cnt",  64'(done_cnt),  64'(e.is_done ? 1 : 0));
    check("fault_cnt", 64'(fault_cnt), 64'(e.is_fault ? 1 : 0));
    if (e.is_done) begin
      check("wr_edge",   64'(wr_k),   64'(e.wr_edge));
      check("tlbadr",    64'(wr_adr), 64'(e.tadr));
      check("tlbdat",    wr_dat,      e.tdat);
      check("done_edge", 64'(done_k), 64'(e.pulse_edge));
    end
    if (e.is_fault) begin
      check("fault_edge",   64'(fault_k),      64'(e.pulse_edge));
      check("req_in_fault", 64'(req_at_fault), 64'd0);
    end
    check("fault_adr",  64'(fault_adr_o), 64'(last_fault_va));
    check("req_cycles", 64'(req_cyc),     64'(e.req_cycles));
    check("idle_edge",  64'(first_idle),  64'(e.idle_edge));
    if (w.hold) begin
      check("next_req_edge", 64'(next_req_k),   64'(e.idle_edge + 1));
      check("next_req_adr",  64'(next_req_adr), 64'({~w.ptbr[31:11], w.va2[31:24], 3'b000}));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not complete");
  end

  initial begin
    walk_t w;
    last_fault_va = '0;
    rst_i = 1'b1; en_i = 1'b1; miss_i = 1'b0; flush_i = 1'b0;
    miss_adr_i = '0; asid_i = '0; ptbr_i = '0;
    mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_dat_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mem_req",   64'(mem_req_o),   64'd0);
    check("rst_mem_adr",   64'(mem_adr_o),   64'd0);
    check("rst_wrtlb",     64'(wrtlb_o),     64'd0);
    check("rst_tlbadr",    64'(tlbadr_o),    64'd0);
    check("rst_tlbdat",    tlbdat_o,         64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_done",      64'(done_o),      64'd0);
    check("rst_fault",     64'(fault_o),     64'd0);
    check("rst_fault_adr", 64'(fault_adr_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed walks.
    run_walk(mk_walk(32'h1234_5678, 8'h5A, 32'h0001_0000, 32'h0002_0001,
                     64'hFF80_0000_1234_5007, 0, 0, 0, 0, -1));            // hit, zero wait
    run_walk(mk_walk(32'h89AB_CDEF, 8'h11, 32'h0004_0800, 32'h0000_0000,
                     64'hFF80_0000_0000_0001, 0, 0, 0, 0, -1));            // L1 invalid
    run_walk(mk_walk(32'h0F0F_1234, 8'h22, 32'h0001_0000, 32'h0003_0001,
                     64'hFF7F_FFFF_FFFF_FFFF, 0, 0, 1, 2, -1));            // L2 invalid
    run_walk(mk_walk(32'h7777_8888, 8'h33, 32'h0001_0000, 32'h0003_0001,
                     64'h0080_0000_0000_0001, 0, 1, 0, 1, -1));            // L2 bus error
    run_walk(mk_walk(32'h4444_2222, 8'h44, 32'h0002_0000, 32'h0003_0001,
                     64'h0080_0000_0000_0001, 1, 0, 2, 0, -1));            // L1 bus error
    run_walk(mk_walk(32'hCAFE_0000, 8'h55, 32'h0002_0000, 32'h0003_0001,
                     64'h0080_0000_0000_0001, 0, 0, 1000, 0, -1));         // L1 timeout
    run_walk(mk_walk(32'hBEEF_4000, 8'h66, 32'h0002_0000, 32'h0003_0001,
                     64'h0080_0000_0000_0001, 0, 0, 1, 1000, -1));         // L2 timeout
    run_walk(mk_walk(32'h1357_9BDF, 8'h77, 32'h0001_0000, 32'h0005_0001,
                     64'h0080_0000_0000_0001, 0, 0, 0, 3, 1));             // flush mid-L2
    run_walk(mk_walk(32'h2468_ACE0, 8'h78, 32'h0001_0000, 32'h0005_0001,
                     64'h0080_0000_0000_0001, 0, 0, 2, 0, 0));             // flush in L1
    run_walk(mk_walk(32'h3141_5926, 8'h79, 32'h0001_0000, 32'h0005_0001,
                     64'h5580_0000_ABCD_0001, 0, 0, 0, 1, 3));             // flush in WRITE
    run_walk(mk_walk(32'h2718_2818, 8'h7A, 32'h0001_0000, 32'h0000_0000,
                     64'h0080_0000_0000_0001, 0, 0, 0, 0, 1));             // flush in FAULT

    // Randomized walks.
    for (int i = 0; i < 40; i++) begin
      w = mk_walk($urandom, 8'($urandom), $urandom, $urandom, {$urandom, $urandom},
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 4), $urandom_range(0, 4), -1);
      w.l1[0]    = ($urandom_range(0, 9) != 0);
      w.l2[VBIT] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) w.flush_at = $urandom_range(0, w.w1 + w.w2 + 3);
      run_walk(w);
    end

    // Enable low: misses ignored; a stray ack in IDLE does nothing.
    en_i = 1'b0; miss_i = 1'b1; miss_adr_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      check("en_low_busy", 64'(busy_o),    64'd0);
      check("en_low_req",  64'(mem_req_o), 64'd0);
    end
    miss_i = 1'b0; en_i = 1'b1;
    mem_ack_i = 1'b1; mem_dat_i = 64'hFFFF_FFFF_0000_2001;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    check("late_ack_busy",  64'(busy_o),  64'd0);
    check("late_ack_wrtlb", 64'(wrtlb_o), 64'd0);
    check("late_ack_fault", 64'(fault_o), 64'd0);

    // Back-to-back: miss held high with a new va during the walk.
    w = mk_walk(32'h0BAD_F00D, 8'h99, 32'h0001_0000, 32'h0006_0001,
                64'h0080_0000_1111_0001, 0, 0, 1, 1, -1);
    w.hold = 1'b1; w.va2 = 32'hA5A5_5A5A;
    run_walk(w);

    // Reset mid-walk (the second walk is waiting for its L1 ack).
    miss_i = 1'b0;
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #3 rst_i = 1'b1;
    #1;
    check("mid_rst_busy",    64'(busy_o),    64'd0);
    check("mid_rst_req",     64'(mem_req_o), 64'd0);
    check("mid_rst_tlbadr",  64'(tlbadr_o),  64'd0);
    check("mid_rst_tlbdat",  tlbdat_o,       64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      check("mid_rst_pulses", 64'({wrtlb_o, done_o, fault_o}), 64'd0);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_busy", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
